// File: rtl/id_pipe_pkg.sv
// Shared RV32I decode constants, immediate-format enum and immediate builder.
// Pure definitions: no latency, no flow control.
package id_pipe_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] INST_TYPE_R = 7'b0110011;
  localparam logic [6:0] INST_TYPE_I = 7'b0010011;
  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;
  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_AUIPC  = 7'b0010111;

  localparam logic [2:0] INST_ADD_SUB = 3'b000;
  localparam logic [2:0] INST_SR      = 3'b101;
  localparam logic [2:0] INST_SLLI    = 3'b001;
  localparam logic [2:0] INST_SRI     = 3'b101;
  localparam logic [2:0] INST_LB      = 3'b000;
  localparam logic [2:0] INST_LH      = 3'b001;
  localparam logic [2:0] INST_LW      = 3'b010;
  localparam logic [2:0] INST_LBU     = 3'b100;
  localparam logic [2:0] INST_LHU     = 3'b101;
  localparam logic [2:0] INST_SB      = 3'b000;
  localparam logic [2:0] INST_SH      = 3'b001;
  localparam logic [2:0] INST_SW      = 3'b010;
  localparam logic [2:0] INST_BEQ     = 3'b000;
  localparam logic [2:0] INST_BNE     = 3'b001;
  localparam logic [2:0] INST_BLT     = 3'b100;
  localparam logic [2:0] INST_BGE     = 3'b101;
  localparam logic [2:0] INST_BLTU    = 3'b110;
  localparam logic [2:0] INST_BGEU    = 3'b111;
  localparam logic [2:0] INST_JALR_F3 = 3'b000;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   imm_gen = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm_gen = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm_gen = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm_gen = {inst[31:12], 12'd0};
      IMM_J:   imm_gen = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_gen = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decode + immediate generation; illegal encodings collapse to a NOP.
// Zero latency, no flow control; illegal flag is live only with ID_ILLEGAL_TRAP_EN.
module id_decode import id_pipe_pkg::*; #(
  parameter int XLEN      = XLEN_DEF,
  parameter int RF_ADDR_W = 5
) (
  input  logic [31:0]          inst,
  output logic [RF_ADDR_W-1:0] rs1_addr,
  output logic [RF_ADDR_W-1:0] rs2_addr,
  output logic [RF_ADDR_W-1:0] rd_addr,
  output logic                 reg_w_ena,
  output logic                 mem_r_ena,
  output logic                 mem_w_ena,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       legal;
  logic       use_rs1;
  logic       use_rs2;
  logic       wen;
  logic       ren;
  logic       men;
  imm_fmt_e   fmt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wen     = WRITE_DISABLE;
    ren     = READ_DISABLE;
    men     = WRITE_DISABLE;
    fmt     = IMM_NONE;
    case (opcode)
      INST_TYPE_R: begin
        legal   = (funct7 == FUNCT7_BASE) ||
                  (funct7 == FUNCT7_ALT && (funct3 == INST_ADD_SUB || funct3 == INST_SR));
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wen     = WRITE_ENABLE;
      end
      INST_TYPE_I: begin
        // Shift-immediates reuse imm[11:5] as funct7
        case (funct3)
          INST_SLLI: legal = (funct7 == FUNCT7_BASE);
          INST_SRI:  legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          default:   legal = 1'b1;
        endcase
        use_rs1 = 1'b1;
        wen     = WRITE_ENABLE;
        fmt     = IMM_I;
      end
      INST_TYPE_L: begin
        legal   = funct3 inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
        use_rs1 = 1'b1;
        wen     = WRITE_ENABLE;
        ren     = READ_ENABLE;
        fmt     = IMM_I;
      end
      INST_TYPE_S: begin
        legal   = funct3 inside {INST_SB, INST_SH, INST_SW};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        men     = WRITE_ENABLE;
        fmt     = IMM_S;
      end
      INST_TYPE_B: begin
        legal   = funct3 inside {INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        fmt     = IMM_B;
      end
      INST_JAL: begin
        legal = 1'b1;
        wen   = WRITE_ENABLE;
        fmt   = IMM_J;
      end
      INST_JALR: begin
        legal   = (funct3 == INST_JALR_F3);
        use_rs1 = 1'b1;
        wen     = WRITE_ENABLE;
        fmt     = IMM_I;
      end
      INST_LUI, INST_AUIPC: begin
        legal = 1'b1;
        wen   = WRITE_ENABLE;
        fmt   = IMM_U;
      end
      default: ;
    endcase
    if (!legal) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wen     = WRITE_DISABLE;
      ren     = READ_DISABLE;
      men     = WRITE_DISABLE;
      fmt     = IMM_NONE;
    end
  end

  assign rs1_addr  = use_rs1 ? RF_ADDR_W'(inst[19:15]) : '0;
  assign rs2_addr  = use_rs2 ? RF_ADDR_W'(inst[24:20]) : '0;
  assign rd_addr   = wen ? RF_ADDR_W'(rd) : '0;
  assign reg_w_ena = wen & (rd != ZERO_REG);
  assign mem_r_ena = ren;
  assign mem_w_ena = men;
  assign imm       = XLEN'(signed'(imm_gen(inst, fmt)));

`ifdef ID_ILLEGAL_TRAP_EN
  assign illegal = ~legal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage: 1-cycle latency, valid/ready out, load-use bubble, post-jump shadow discard.
// Stalls hold all outputs; ID_ILLEGAL_TRAP_EN makes illegal_o flag NOP-ed illegal decodes.
module id_pipe import id_pipe_pkg::*; #(
  parameter int XLEN        = XLEN_DEF,
  parameter int RF_ADDR_W   = 5,
  parameter int JUMP_SHADOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          inst_i,
  input  logic [XLEN-1:0]      inst_addr_i,
  output logic [RF_ADDR_W-1:0] reg1_r_addr_o,
  output logic [RF_ADDR_W-1:0] reg2_r_addr_o,
  input  logic [XLEN-1:0]      reg1_r_data_i,
  input  logic [XLEN-1:0]      reg2_r_data_i,
  input  logic                 ex_jump_ena_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          inst_o,
  output logic [XLEN-1:0]      inst_addr_o,
  output logic [XLEN-1:0]      reg1_r_data_o,
  output logic [XLEN-1:0]      reg2_r_data_o,
  output logic [XLEN-1:0]      imm_o,
  output logic                 reg_w_ena_o,
  output logic [RF_ADDR_W-1:0] reg_w_addr_o,
  output logic                 mem_w_ena_o,
  output logic                 mem_r_ena_o,
  output logic                 illegal_o
);

  localparam logic [3:0] SHADOW_INIT = 4'(JUMP_SHADOW - 1);

  logic [RF_ADDR_W-1:0] dec_rd;
  logic                 dec_wen;
  logic                 dec_ren;
  logic                 dec_men;
  logic [XLEN-1:0]      dec_imm;
  logic                 dec_illegal;
  logic [3:0]           shadow_cnt;
  logic                 hazard;
  logic                 discard;
  logic                 load;

  id_decode #(.XLEN(XLEN), .RF_ADDR_W(RF_ADDR_W)) u_decode (
    .inst      (inst_i),
    .rs1_addr  (reg1_r_addr_o),
    .rs2_addr  (reg2_r_addr_o),
    .rd_addr   (dec_rd),
    .reg_w_ena (dec_wen),
    .mem_r_ena (dec_ren),
    .mem_w_ena (dec_men),
    .imm       (dec_imm),
    .illegal   (dec_illegal)
  );

  // Unused read ports are address 0, so a nonzero rd can only match a real source
  assign hazard = out_valid_o & mem_r_ena_o & (reg_w_addr_o != '0) &
                  ((reg_w_addr_o == reg1_r_addr_o) | (reg_w_addr_o == reg2_r_addr_o));

  // Wrong-path input is always swallowed, regardless of hazard or downstream stall
  assign discard    = ex_jump_ena_i | (shadow_cnt != 4'd0);
  assign in_ready_o = discard | (~hazard & (~out_valid_o | out_ready_i));
  assign load       = in_valid_i & in_ready_o & ~discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_cnt    <= 4'd0;
      out_valid_o   <= 1'b0;
      inst_o        <= '0;
      inst_addr_o   <= '0;
      reg1_r_data_o <= '0;
      reg2_r_data_o <= '0;
      imm_o         <= '0;
      reg_w_ena_o   <= 1'b0;
      reg_w_addr_o  <= '0;
      mem_w_ena_o   <= 1'b0;
      mem_r_ena_o   <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      if (ex_jump_ena_i)
        shadow_cnt <= SHADOW_INIT;
      else if (shadow_cnt != 4'd0)
        shadow_cnt <= shadow_cnt - 4'd1;

      if (ex_jump_ena_i) begin
        out_valid_o <= 1'b0;
        illegal_o   <= 1'b0;
      end else if (load) begin
        out_valid_o   <= 1'b1;
        inst_o        <= inst_i;
        inst_addr_o   <= inst_addr_i;
        reg1_r_data_o <= reg1_r_data_i;
        reg2_r_data_o <= reg2_r_data_i;
        imm_o         <= dec_imm;
        reg_w_ena_o   <= dec_wen;
        reg_w_addr_o  <= dec_rd;
        mem_w_ena_o   <= dec_men;
        mem_r_ena_o   <= dec_ren;
        illegal_o     <= dec_illegal;
      end else if (out_ready_i) begin
        // Drained with nothing to take (idle or load-use bubble)
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
